// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store unit.
package mem_access_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned BE_W    = 4;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_ACCESS = 2'd1,
    MA_DONE   = 2'd2
  } ma_state_e;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [XLEN-1:0]    wdata;
    logic [BE_W-1:0]    be;
  } dm_req_t;

  function automatic logic is_byte(input logic [2:0] f);
    return (f == LS_B) || (f == LS_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] f);
    return (f == LS_H) || (f == LS_HU);
  endfunction

  // Unlisted FUNC3 codes behave as word accesses.
  function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] a);
    if (is_byte(f)) return 1'b0;
    if (is_half(f)) return a[0];
    return a != 2'b00;
  endfunction

  function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f, input logic [1:0] a);
    if (is_byte(f)) return 4'b0001 << a;
    if (is_half(f)) return 4'b0011 << {a[1], 1'b0};
    return 4'b1111;
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [2:0] f, input logic [XLEN-1:0] d);
    if (is_byte(f)) return {4{d[7:0]}};
    if (is_half(f)) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic dm_req_t build_req(input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] data,
                                        input logic [2:0]      f);
    dm_req_t r;
    r.addr  = addr[XLEN-1:2];
    r.wdata = lane_data(f, data);
    r.be    = byte_en(f, addr[1:0]);
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Lane select and sign/zero extension of a memory read word.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    data_c = word;
    case (func3)
      LS_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   data_c = {24'h0, byte_sel};
      LS_H:    data_c = {{16{half_sel[15]}}, half_sel};
      LS_HU:   data_c = {16'h0, half_sel};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with a stalling handshake to word-organised data memory.
// Optional access timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 9
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [XLEN-1:0]     ALU_RESULT,
  input  logic [XLEN-1:0]     STORE_DATA,
  input  logic                MEM_READ,
  input  logic                MEM_WRITE,
  input  logic [2:0]          FUNC3,
  output logic                BUSYWAIT,
  output logic [XLEN-1:0]     LOAD_DATA,
  output logic                MISALIGNED,
  output logic [WADDR_W-1:0]  DM_ADDRESS,
  output logic [XLEN-1:0]     DM_WRITEDATA,
  output logic [BE_W-1:0]     DM_BYTE_EN,
  output logic                DM_READ,
  output logic                DM_WRITE,
  input  logic [XLEN-1:0]     DM_READDATA,
  input  logic                DM_BUSYWAIT,
  output logic                BUS_ERROR
);

  ma_state_e       state;
  dm_req_t         req_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      func3_q;
  logic            is_load_q;
  logic [XLEN-1:0] load_ext_c;
  logic            request_c;
  logic            mis_c;

  assign request_c = MEM_READ | MEM_WRITE;
  assign mis_c     = is_misaligned(FUNC3, ALU_RESULT[1:0]);

  // Stall asserts in the request cycle itself so the pipeline freezes immediately.
  assign BUSYWAIT   = (state == MA_ACCESS) || ((state == MA_IDLE) && request_c && !mis_c);
  assign MISALIGNED = (state == MA_IDLE) && request_c && mis_c;

  assign DM_ADDRESS   = req_q.addr;
  assign DM_WRITEDATA = req_q.wdata;
  assign DM_BYTE_EN   = req_q.be;

  mem_access_unit_load_align u_load_align (
    .word    (DM_READDATA),
    .addr_lo (addr_lo_q),
    .func3   (func3_q),
    .data_c  (load_ext_c)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 bus_error_q;

  assign BUS_ERROR = bus_error_q;
`else
  logic [CNT_WIDTH-1:0] unused_timeout;

  assign unused_timeout = CNT_WIDTH'(TIMEOUT_CYCLES);
  assign BUS_ERROR      = 1'b0;
`endif

  // Access FSM; strobes and payload are registered on the IDLE->ACCESS edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= MA_IDLE;
      req_q     <= '0;
      addr_lo_q <= 2'b00;
      func3_q   <= LS_W;
      is_load_q <= 1'b0;
      DM_READ   <= 1'b0;
      DM_WRITE  <= 1'b0;
      LOAD_DATA <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      wait_cnt    <= '0;
      bus_error_q <= 1'b0;
`endif
    end else begin
      case (state)
        MA_IDLE: begin
          if (request_c && !mis_c) begin
            // A simultaneous read and write is executed as a store.
            req_q     <= build_req(ALU_RESULT, STORE_DATA, FUNC3);
            addr_lo_q <= ALU_RESULT[1:0];
            func3_q   <= FUNC3;
            is_load_q <= !MEM_WRITE;
            DM_READ   <= !MEM_WRITE;
            DM_WRITE  <= MEM_WRITE;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            state     <= MA_ACCESS;
          end
        end
        MA_ACCESS: begin
          if (!DM_BUSYWAIT) begin
            if (is_load_q) LOAD_DATA <= load_ext_c;
            DM_READ  <= 1'b0;
            DM_WRITE <= 1'b0;
            state    <= MA_DONE;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            LOAD_DATA   <= '0;
            DM_READ     <= 1'b0;
            DM_WRITE    <= 1'b0;
            bus_error_q <= 1'b1;
            state       <= MA_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
`endif
        end
        MA_DONE: begin
          // The request is still present here but belongs to the retiring instruction.
`ifdef MEM_ACCESS_TIMEOUT_EN
          bus_error_q <= 1'b0;
`endif
          state <= MA_IDLE;
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit directly downstream of the EX-stage ALU. It takes the ALU result as the effective address plus the store operand and access type, and runs a stalling handshake with a word-organised data memory. It generates byte enables and store-data lane placement, and sign/zero-extends load data. It drives BUSYWAIT to freeze the pipeline while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 256, max MEM_BUSYWAIT cycles before abort (used only with the optional feature)
CNT_WIDTH, 9, width of timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
CLK  in  1  single clock, rising edge
RESET  in  1  synchronous, active-low reset
ALU_RESULT  in  32  effective byte address
STORE_DATA  in  32  rs2 value for stores
MEM_READ  in  1  load request (level, held by pipeline while stalled)
MEM_WRITE  in  1  store request (level)
FUNC3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
BUSYWAIT  out  1  pipeline stall
LOAD_DATA  out  32  extended load result, valid in DONE
MISALIGNED  out  1  one-cycle pulse, misaligned request dropped
DM_ADDRESS  out  30  word address = ALU_RESULT[31:2]
DM_WRITEDATA  out  32  lane-placed store data
DM_BYTE_EN  out  4  byte enables
DM_READ  out  1  memory read strobe (registered)
DM_WRITE  out  1  memory write strobe (registered)
DM_READDATA  in  32  memory read word
DM_BUSYWAIT  in  1  memory busy
BUS_ERROR  out  1  timeout pulse (tied 0 without the optional feature)

Behaviour:
- Reset (RESET=0 at a CLK edge): state IDLE. DM_READ, DM_WRITE, DM_BYTE_EN, DM_ADDRESS, DM_WRITEDATA, LOAD_DATA, MISALIGNED and BUS_ERROR all 0. BUSYWAIT is 0 in IDLE with no request. A reset during ACCESS drops the strobes at that edge; the in-flight access is abandoned.
- FSM states: IDLE, ACCESS, DONE.
- IDLE with an aligned request: BUSYWAIT=1 combinationally in the same cycle. At the edge, register address, byte enables and write data, assert the DM_READ or DM_WRITE strobe, and go to ACCESS.
- IDLE with a misaligned request: no transition, no stall. MISALIGNED=1 for exactly that cycle.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
- ACCESS: BUSYWAIT=1 and strobes held.
  - DM_BUSYWAIT=1: stay.
  - DM_BUSYWAIT=0: capture DM_READDATA on loads, drop the strobes, go to DONE.
- DONE: BUSYWAIT=0 and LOAD_DATA valid; the pipeline advances on this edge. The next state is IDLE unconditionally; the still-present request is not re-sampled.
- Minimum latency: 2 stall cycles (IDLE, ACCESS) with zero-wait memory. N wait cycles add N.
- MEM_READ and MEM_WRITE both high: treated as a store.
- FUNC3 values 011, 110 and 111: treated as W.
- Byte enables:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<{addr[1],1'b0}
  - W: 4'b1111
  - Loads use the same enables.
- Store data: B replicates STORE_DATA[7:0] to all 4 lanes; H replicates [15:0] to both halves; W passes through.
- Load data: select the lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- LOAD_DATA holds its value until the next completed load.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN.
- Defined: a counter runs in ACCESS while DM_BUSYWAIT=1 and clears on entry to ACCESS. On reaching TIMEOUT_CYCLES, drop the strobes, pulse BUS_ERROR for 1 cycle, set LOAD_DATA=0 and go to DONE.
- Undefined: no counter; ACCESS waits indefinitely and BUS_ERROR is constant 0.

Decomposition:
- Shared encodings file:
  - FUNC3 load/store constants (LS_B, LS_H, LS_W, LS_BU, LS_HU)
  - FSM state encodings (MA_IDLE, MA_ACCESS, MA_DONE)
- Sub-module load_align: purely combinational lane select plus sign/zero extend from the word, addr[1:0] and FUNC3.

Test Plan:
- LW, addr 0x100, memory returns 0xDEADBEEF with 0 waits -> DM_READ for 1 cycle, DM_ADDRESS=0x40, BUSYWAIT high 2 cycles, LOAD_DATA=0xDEADBEEF in DONE.
- LB at addr 0x103 / LBU at 0x103, word 0x80FF_0000 -> DM_BYTE_EN=4'b1000; LOAD_DATA=0xFFFFFF80 / 0x00000080.
- SH at addr 0x202, STORE_DATA 0x1234ABCD, 3 wait cycles -> DM_WRITEDATA=0xABCDABCD, DM_BYTE_EN=4'b1100, BUSYWAIT high 5 cycles.
- LW at addr 0x102 -> MISALIGNED pulse 1 cycle, no DM_READ, BUSYWAIT stays 0.
- RESET low in the 2nd ACCESS cycle of a store -> DM_WRITE=0 next cycle, state IDLE, all outputs 0.
- MEM_ACCESS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, DM_BUSYWAIT stuck at 1 -> BUS_ERROR pulse after 4 ACCESS cycles, LOAD_DATA=0, BUSYWAIT released in DONE.
